div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameters: none; data width fixed at 32 bits.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 div_in.rs1  input  32  dividend.
REQ-005 div_in.rs2  input  32  divisor.
REQ-006 div_in.div_op  input  4  one-hot op select: div, divu, rem, remu.
REQ-007 div_in.enable  input  1  start pulse; operands and op sampled on the same cycle.
REQ-008 div_in.clear  input  1  flush; abort in-flight operation.
REQ-009 div_out.res  output  32  quotient or remainder, valid only while ready=1.
REQ-010 div_out.ready  output  1  one-cycle result-valid pulse.

Function
REQ-011 Implements RV32M DIV/DIVU/REM/REMU with an iterative restoring divider, one quotient bit per cycle.
REQ-012 FSM states: IDLE, BUSY, FINISH.
  - IDLE -> BUSY on enable=1 and clear=0.
  - BUSY -> FINISH when the iteration counter reaches 0.
  - FINISH -> IDLE unconditionally.
REQ-013 On start: latch the op; latch absolute values of the operands (signed ops) or raw operands (unsigned ops); latch result-sign flags; load counter with 31.
REQ-014 BUSY: each cycle, shift partial remainder/quotient left one bit, trial-subtract the divisor, restore on negative, decrement the counter; exactly 32 BUSY cycles.
REQ-015 FINISH:
  - Apply sign correction: quotient negated if operand signs differ; remainder takes the sign of the dividend.
  - Drive res; assert ready for exactly one cycle.
REQ-016 Latency: enable sampled at edge N -> ready=1 in the cycle after edge N+33.
REQ-017 enable while BUSY or FINISH is ignored; no queuing.
REQ-018 clear=1 in any state -> next state IDLE, no ready pulse; clear wins over a simultaneous enable.
REQ-019 Divide by zero:
  - div/divu return 0xFFFFFFFF.
  - rem/remu return rs1.
REQ-020 Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF):
  - div returns 0x80000000.
  - rem returns 0.
REQ-021 res = 0 whenever ready=0.

Reset
REQ-022 reset=1 at a clock edge:
  - state IDLE, counter 0, all datapath registers 0.
  - ready=0, res=0.
REQ-023 Reset mid-operation discards the operation; no ready pulse follows.

Configuration
REQ-024 Macro DIV_EARLY_EN:
  - When defined, divide-by-zero and signed overflow bypass BUSY (IDLE -> FINISH) and ready rises in the cycle after the start edge (latency 1).
  - When undefined, these cases run the full 33-cycle sequence and produce identical result values.

Structure
REQ-025 div_in_type, div_out_type and div_op_type (one-hot struct) belong in the shared wires package, alongside the existing ALU types.
REQ-026 One combinational sub-module, div_step, computes a single restoring iteration: partial remainder, divisor -> next remainder, quotient bit.

Verification
REQ-027 divu rs1=100, rs2=7 -> res=14 with ready at start+33; remu same operands -> res=2.
REQ-028 rem rs1=0xFFFFFFF9 (-7), rs2=2 -> res=0xFFFFFFFF (-1); div same operands -> res=0xFFFFFFFD (-3).
REQ-029 div rs1=5, rs2=0 -> res=0xFFFFFFFF; rem -> res=5; latency 1 with DIV_EARLY_EN, 33 without.
REQ-030 div rs1=0x80000000, rs2=0xFFFFFFFF -> res=0x80000000; rem -> res=0.
REQ-031 Start divu 100/7, assert clear at start+10 -> no ready pulse; immediately start divu 9/3 -> res=3 at its start+33.
REQ-032 Second enable (rs1=1, rs2=1) at start+5 during divu 100/7 -> ignored; single ready pulse with res=14; reset at start+20 -> ready stays 0, res=0.

Source files
------------

// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared wires package for the execute-stage units. It holds the divider's
// port bundles (div_in_type / div_out_type), its one-hot op select
// (div_op_type), the FSM state type and two small two's-complement helpers.
//
// Optional feature: DIV_EARLY_EN (see div_unit.sv) -- no package content
// depends on it.
// -----------------------------------------------------------------------------
package div_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  // One-hot operation select; exactly one field is expected to be set.
  typedef struct packed {
    logic div;
    logic divu;
    logic rem;
    logic remu;
  } div_op_type;

  typedef struct packed {
    logic [XLEN-1:0] rs1;     // dividend
    logic [XLEN-1:0] rs2;     // divisor
    div_op_type      div_op;  // op select
    logic            enable;  // start pulse
    logic            clear;   // flush
  } div_in_type;

  typedef struct packed {
    logic [XLEN-1:0] res;     // result, zero unless ready
    logic            ready;   // one-cycle result-valid pulse
  } div_out_type;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    FINISH = 2'd2
  } div_state_type;

  // Two's-complement negation.
  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
    return (~v) + 32'd1;
  endfunction

  // Magnitude of v when treated as signed; raw v otherwise.
  // abs(0x80000000) stays 0x80000000, which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v,
                                             input logic            is_signed);
    logic [XLEN-1:0] r;
    if (is_signed && v[XLEN-1]) begin
      r = twos_neg(v);
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring-division iteration, purely combinational.
//   rem_in  : current partial remainder (always < divisor in normal operation)
//   bit_in  : next dividend bit shifted into the remainder
//   divisor : divisor magnitude
//   rem_out : partial remainder after the trial subtract / restore
//   q_bit   : quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step
  import div_unit_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic            bit_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] diff_s;

  assign shifted_s = {rem_in, bit_in};
  // Because shifted < 2*divisor, a 33-bit difference is enough: bit 32 is set
  // exactly when the trial subtract goes negative.
  assign diff_s    = shifted_s - {1'b0, divisor};

  // Keep the difference when it is non-negative, otherwise restore.
  always_comb begin
    rem_out = shifted_s[XLEN-1:0];
    q_bit   = 1'b0;
    if (diff_s[XLEN]) begin
      rem_out = shifted_s[XLEN-1:0];
      q_bit   = 1'b0;
    end else begin
      rem_out = diff_s[XLEN-1:0];
      q_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// RV32M DIV / DIVU / REM / REMU using an iterative restoring divider that
// retires one quotient bit per cycle (32 BUSY cycles, then FINISH).
//
// Ports
//   reset   : synchronous, active-high
//   clock   : rising-edge clock
//   div_in  : rs1, rs2, one-hot div_op, enable (start), clear (flush)
//   div_out : res (zero unless ready), ready (one-cycle pulse)
//
// Latency: enable sampled at edge N -> ready high after edge N+33.
//
// Optional feature: define DIV_EARLY_EN to let divide-by-zero and signed
// overflow skip BUSY (IDLE -> FINISH), giving ready after edge N+1. Without
// it those cases walk the full sequence and yield the same values.
// -----------------------------------------------------------------------------
module div_unit
  import div_unit_pkg::*;
(
  input  logic        reset,
  input  logic        clock,
  input  div_in_type  div_in,
  output div_out_type div_out
);

`ifdef DIV_EARLY_EN
  localparam logic EARLY_EN = 1'b1;
`else
  localparam logic EARLY_EN = 1'b0;
`endif

  div_state_type    state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]  rem_r;     // partial remainder
  logic [XLEN-1:0]  quo_r;     // dividend bits shift out the top, quotient bits in the bottom
  logic [XLEN-1:0]  dvs_r;     // divisor magnitude
  logic             want_rem_r, neg_q_r, neg_r_r, dbz_r, ovf_r;
  logic [XLEN-1:0]  res_r;
  logic             ready_r;

  logic             is_signed_s, want_rem_s, dbz_s, ovf_s, special_s, start_s;
  logic [XLEN-1:0]  step_rem_s;
  logic             step_q_s;
  logic [XLEN-1:0]  q_fin_s, r_fin_s, res_fin_s;

  assign is_signed_s = div_in.div_op.div | div_in.div_op.rem;
  assign want_rem_s  = (div_in.div_op.rem | div_in.div_op.remu) &
                       ~(div_in.div_op.div | div_in.div_op.divu);
  assign dbz_s       = (div_in.rs2 == 32'd0);
  assign ovf_s       = is_signed_s && (div_in.rs1 == 32'h8000_0000) &&
                       (div_in.rs2 == 32'hFFFF_FFFF);
  assign special_s   = dbz_s | ovf_s;
  assign start_s     = (state_r == IDLE) && div_in.enable && !div_in.clear;

  div_step u_step (
    .rem_in  (rem_r),
    .bit_in  (quo_r[XLEN-1]),
    .divisor (dvs_r),
    .rem_out (step_rem_s),
    .q_bit   (step_q_s)
  );

  // Next-state logic: clear always returns to IDLE, FINISH lasts one cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          if (EARLY_EN && special_s) begin
            state_s = FINISH;
          end else begin
            state_s = BUSY;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (div_in.clear) begin
          state_s = IDLE;
        end else if (cnt_r == 5'd0) begin
          state_s = FINISH;
        end else begin
          state_s = BUSY;
        end
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Sign correction and the RV32M corner-case overrides for the final result.
  always_comb begin
    q_fin_s   = quo_r;
    r_fin_s   = rem_r;
    res_fin_s = 32'd0;
    if (dbz_r) begin
      q_fin_s = 32'hFFFF_FFFF;
    end else if (ovf_r) begin
      q_fin_s = 32'h8000_0000;
    end else if (neg_q_r) begin
      q_fin_s = twos_neg(quo_r);
    end else begin
      q_fin_s = quo_r;
    end
    // A zero-divisor remainder equals |rs1| here, so the dividend sign restores rs1.
    if (ovf_r) begin
      r_fin_s = 32'd0;
    end else if (neg_r_r) begin
      r_fin_s = twos_neg(rem_r);
    end else begin
      r_fin_s = rem_r;
    end
    if (want_rem_r) begin
      res_fin_s = r_fin_s;
    end else begin
      res_fin_s = q_fin_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: operand capture, iteration and registered result/ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r      <= 5'd0;
      rem_r      <= 32'd0;
      quo_r      <= 32'd0;
      dvs_r      <= 32'd0;
      want_rem_r <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      dbz_r      <= 1'b0;
      ovf_r      <= 1'b0;
      res_r      <= 32'd0;
      ready_r    <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      res_r   <= 32'd0;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            want_rem_r <= want_rem_s;
            neg_q_r    <= is_signed_s & (div_in.rs1[XLEN-1] ^ div_in.rs2[XLEN-1]);
            neg_r_r    <= is_signed_s & div_in.rs1[XLEN-1];
            dbz_r      <= dbz_s;
            ovf_r      <= ovf_s;
            dvs_r      <= abs_if(div_in.rs2, is_signed_s);
            quo_r      <= abs_if(div_in.rs1, is_signed_s);
            cnt_r      <= 5'd31;
            // When BUSY is skipped the remainder path must already hold |rs1|.
            if (EARLY_EN && dbz_s) begin
              rem_r <= abs_if(div_in.rs1, is_signed_s);
            end else begin
              rem_r <= 32'd0;
            end
          end
        end
        BUSY: begin
          if (!div_in.clear) begin
            rem_r <= step_rem_s;
            quo_r <= {quo_r[XLEN-2:0], step_q_s};
            if (cnt_r != 5'd0) begin
              cnt_r <= cnt_r - 5'd1;
            end else begin
              cnt_r <= 5'd0;
            end
          end
        end
        FINISH: begin
          if (!div_in.clear) begin
            ready_r <= 1'b1;
            res_r   <= res_fin_s;
          end
        end
        default: begin
          ready_r <= 1'b0;
          res_r   <= 32'd0;
        end
      endcase
    end
  end

  assign div_out.res   = res_r;
  assign div_out.ready = ready_r;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Self-checking bench for div_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
// Honours DIV_EARLY_EN for the expected latency of zero-divisor / overflow.
// -----------------------------------------------------------------------------
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  div_in_type  div_in;
  div_out_type div_out;

  int checks_cnt = 0;
  int errors_cnt = 0;

`ifdef DIV_EARLY_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 33;
`endif
  localparam int NORMAL_LAT = 33;

  localparam int OP_DIV  = 0;
  localparam int OP_DIVU = 1;
  localparam int OP_REM  = 2;
  localparam int OP_REMU = 3;

  div_unit dut (
    .reset   (reset),
    .clock   (clock),
    .div_in  (div_in),
    .div_out (div_out)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic div_op_type op_bits(input int op);
    div_op_type o;
    o = '0;
    case (op)
      OP_DIV:  o.div  = 1'b1;
      OP_DIVU: o.divu = 1'b1;
      OP_REM:  o.rem  = 1'b1;
      default: o.remu = 1'b1;
    endcase
    return o;
  endfunction

  function automatic bit is_special(input int op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ||
           (((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  // RV32M semantics from plain 64-bit arithmetic (truncating division).
  function automatic logic [31:0] ref_res(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    case (op)
      OP_DIV:  r = (b == 32'd0) ? -1 : sa / sb;
      OP_REM:  r = (b == 32'd0) ? sa : sa % sb;
      OP_DIVU: r = (b == 32'd0) ? longint'(32'hFFFF_FFFF) : longint'(a) / longint'(b);
      default: r = (b == 32'd0) ? longint'(a) : longint'(a) % longint'(b);
    endcase
    return r[31:0];
  endfunction

  // Start one op, watch 41 cycles, optionally inject a second enable,
  // a clear or a reset at start+N. exp_lat < 0 means no ready pulse expected.
  task automatic run_op(input string tag, input int op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_res,
                        input int en2_at, input int clr_at, input int rst_at);
    int          got_lat;
    int          pulses;
    logic [31:0] got_res;
    logic        dirty;
    got_lat = -1;
    pulses  = 0;
    got_res = 32'd0;
    dirty   = 1'b0;
    @(negedge clock);
    div_in.rs1    = a;
    div_in.rs2    = b;
    div_in.div_op = op_bits(op);
    div_in.enable = 1'b1;
    div_in.clear  = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (div_out.ready) begin
        pulses++;
        if (got_lat < 0) begin
          got_lat = k;
          got_res = div_out.res;
        end
      end else if (div_out.res !== 32'd0) begin
        dirty = 1'b1;
      end
      if (k == 0) div_in.enable = 1'b0;
      if (en2_at > 0 && k == en2_at - 1) begin
        div_in.rs1    = 32'd1;
        div_in.rs2    = 32'd1;
        div_in.enable = 1'b1;
      end
      if (en2_at > 0 && k == en2_at) div_in.enable = 1'b0;
      if (clr_at > 0 && k == clr_at - 1) div_in.clear = 1'b1;
      if (clr_at > 0 && k == clr_at) div_in.clear = 1'b0;
      if (rst_at > 0 && k == rst_at - 1) reset = 1'b1;
      if (rst_at > 0 && k == rst_at) reset = 1'b0;
    end
    check_val({tag, "_lat"}, got_lat, exp_lat);
    check_val({tag, "_pulses"}, pulses, (exp_lat < 0) ? 0 : 1);
    check_val({tag, "_idle_res"}, {31'd0, dirty}, 32'd0);
    if (exp_lat >= 0) check_val({tag, "_res"}, got_res, exp_res);
  endtask

  initial begin
    int          op, mode, lat;
    logic [31:0] a, b;
    div_in = '0;
    reset  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_val("reset_ready", {31'd0, div_out.ready}, 32'd0);
    check_val("reset_res", div_out.res, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, NORMAL_LAT, 32'd14, -1, -1, -1);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, NORMAL_LAT, 32'd2, -1, -1, -1);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, NORMAL_LAT, 32'hFFFF_FFFF, -1, -1, -1);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, NORMAL_LAT, 32'hFFFF_FFFD, -1, -1, -1);
    run_op("div_by0", OP_DIV, 32'd5, 32'd0, SPECIAL_LAT, 32'hFFFF_FFFF, -1, -1, -1);
    run_op("rem_by0", OP_REM, 32'd5, 32'd0, SPECIAL_LAT, 32'd5, -1, -1, -1);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, SPECIAL_LAT, 32'h8000_0000, -1, -1, -1);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, SPECIAL_LAT, 32'd0, -1, -1, -1);
    run_op("divu_clear", OP_DIVU, 32'd100, 32'd7, -1, 32'd0, -1, 10, -1);
    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, NORMAL_LAT, 32'd3, -1, -1, -1);
    run_op("divu_en2", OP_DIVU, 32'd100, 32'd7, NORMAL_LAT, 32'd14, 5, -1, -1);
    run_op("divu_rst", OP_DIVU, 32'd100, 32'd7, -1, 32'd0, -1, -1, 20);

    for (int i = 0; i < 40; i++) begin
      op   = int'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 4));
      a    = $urandom;
      b    = $urandom;
      case (mode)
        1: begin a = 32'($urandom_range(0, 1000)); b = 32'($urandom_range(1, 40)); end
        2: b = 32'd0;
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: begin a = 32'd0 - 32'($urandom_range(1, 500)); b = 32'd0 - 32'($urandom_range(1, 20)); end
        default: begin end
      endcase
      lat = is_special(op, a, b) ? SPECIAL_LAT : NORMAL_LAT;
      run_op($sformatf("rnd%0d", i), op, a, b, lat, ref_res(op, a, b), -1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
